// File: rtl/sine_sequencer.sv
// sine_sequencer: sequences sine-ROM reads into the DAC with a programmable sample tick and phase step.
// Ports: clk/rst (sync, active-high); start/stop requests; div/step/n_periods playback settings
// latched at start; rom_en/rom_addr drive the ROM; dac_en trails rom_en by one cycle for the
// ROM read latency; busy covers RUN and DRAIN; done pulses once per finished playback;
// period_cnt counts completed periods.
module sine_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div,
    input  logic [ADDR_W-1:0] step,
    input  logic [CNT_W-1:0]  n_periods,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              dac_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  period_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_l_q, div_l_d, div_cnt_q, div_cnt_d;
    logic [ADDR_W-1:0] step_l_q, step_l_d, addr_q, addr_d;
    logic [CNT_W-1:0]  n_l_q, n_l_d, per_q, per_d, per_inc;
    logic              stop_pend_q, stop_pend_d, rom_en_q, rom_en_d, dac_en_q, done_q;
    logic [ADDR_W:0]   sum;
    logic              last;
    always_comb begin
        sum         = {1'b0, addr_q} + {1'b0, step_l_q};
        per_inc     = per_q + 1'b1;
        // a playback only ever ends on the carry-out of the phase accumulator
        last        = sum[ADDR_W] && ((n_l_q != '0 && per_inc == n_l_q) || stop_pend_q || stop);
        state_d     = state_q;
        div_l_d     = div_l_q;
        step_l_d    = step_l_q;
        n_l_d       = n_l_q;
        div_cnt_d   = div_cnt_q;
        addr_d      = addr_q;
        per_d       = per_q;
        stop_pend_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                div_l_d   = div;
                step_l_d  = (step == '0) ? ADDR_W'(1) : step;
                n_l_d     = n_periods;
                div_cnt_d = '0;
                addr_d    = '0;
                per_d     = '0;
                state_d   = RUN;
            end
            RUN: begin
                stop_pend_d = stop_pend_q | stop;
                div_cnt_d   = (div_cnt_q == div_l_q) ? '0 : div_cnt_q + 1'b1;
                if (rom_en_q) begin
                    addr_d  = sum[ADDR_W-1:0];
                    per_d   = sum[ADDR_W] ? per_inc : per_q;
                    state_d = last ? DRAIN : RUN;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // registered tick: asserted for the cycle in which the divider will sit at its terminal value
        rom_en_d = (state_d == RUN) && (div_cnt_d == div_l_d);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_l_q     <= '0;
            step_l_q    <= '0;
            n_l_q       <= '0;
            div_cnt_q   <= '0;
            addr_q      <= '0;
            per_q       <= '0;
            stop_pend_q <= 1'b0;
            rom_en_q    <= 1'b0;
            dac_en_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_l_q     <= div_l_d;
            step_l_q    <= step_l_d;
            n_l_q       <= n_l_d;
            div_cnt_q   <= div_cnt_d;
            addr_q      <= addr_d;
            per_q       <= per_d;
            stop_pend_q <= stop_pend_d;
            rom_en_q    <= rom_en_d;
            dac_en_q    <= rom_en_q;
            done_q      <= (state_q == DRAIN);
        end
    end
    assign rom_en     = rom_en_q;
    assign rom_addr   = addr_q;
    assign dac_en     = dac_en_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign period_cnt = per_q;
endmodule

// File: tb/tb_sine_sequencer.sv
// tb_sine_sequencer: directed scoreboard bench for sine_sequencer.
module tb_sine_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [15:0] div = '0;
    logic [5:0] step = '0;
    logic [7:0] n_periods = '0;
    logic       rom_en, dac_en, busy, done;
    logic [5:0] rom_addr;
    logic [7:0] period_cnt;

    sine_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div), .step(step),
        .n_periods(n_periods), .rom_en(rom_en), .rom_addr(rom_addr), .dac_en(dac_en),
        .busy(busy), .done(done), .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int c; int a;} ev_t;
    ev_t  q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   exp_done = 0;
    int   got_done = 0;
    bit   mon = 1'b0;
    logic prev_rom = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            int rel;
            ev_t e;
            rel = cyc - t0;
            chk("dac_en_follows_rom_en", dac_en, prev_rom);
            if (rom_en) begin
                if (q.size() == 0) chk("unexpected_rom_en_cycle", rel, 0);
                else begin
                    e = q.pop_front();
                    chk("rom_en_cycle", rel, e.c);
                    chk("rom_addr", rom_addr, e.a);
                end
            end
            if (done) begin
                chk("done_cycle", rel, exp_done);
                got_done++;
            end
            chk("busy", busy, (rel >= 1 && rel < exp_done));
            prev_rom = rom_en;
        end
    end

    // stop_at: cycle (relative to start) of a stop pulse, 0 = with start, -1 = none
    // start_at: cycle of an extra start pulse during RUN, -1 = none
    task automatic play(input int d, input int s, input int n, input int stop_at, input int start_at);
        int a, per, rel, es, sum, exp_per;
        bit fin;
        es = (s == 0) ? 1 : s;
        a = 0; per = 0; rel = 0; fin = 0;
        q.delete();
        while (!fin) begin
            rel += d + 1;
            q.push_back('{rel, a});
            sum = a + es;
            a = sum % 64;
            if (sum >= 64) begin
                per++;
                fin = (n != 0 && per == n) || (stop_at >= 1 && stop_at <= rel);
            end
        end
        exp_done = rel + 2;
        exp_per = per;
        got_done = 0;
        prev_rom = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; stop = (stop_at == 0);
        div = 16'(d); step = 6'(s); n_periods = 8'(n);
        t0 = cyc;
        mon = 1'b1;
        for (int r = 1; r <= exp_done + 2; r++) begin
            @(posedge clk); #1;
            start = (r == start_at);
            stop = (r == stop_at);
            div = 16'($urandom_range(0, 3));
            step = 6'($urandom_range(0, 63));
            n_periods = 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        mon = 1'b0;
        chk("done_count", got_done, 1);
        chk("period_cnt", period_cnt, exp_per);
        chk("samples_left", q.size(), 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rom_en", rom_en, 0);
        chk("reset_dac_en", dac_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_period_cnt", period_cnt, 0);
        rst = 1'b0;
        play(0, 1, 1, -1, -1);
        play(9, 4, 2, -1, -1);
        play(0, 1, 0, 10, -1);
        play(0, 5, 1, -1, -1);
        play(0, 0, 1, -1, -1);
        play(3, 1, 1, -1, 20);
        play(0, 2, 2, 0, -1);
        // abort by reset in cycle 30 of a div=0 step=1 burst
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b0; div = '0; step = 6'd1; n_periods = 8'd1;
        for (int r = 1; r <= 34; r++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst = (r == 30);
            @(negedge clk);
            if (r == 30) begin
                chk("pre_abort_rom_en", rom_en, 1);
                chk("pre_abort_addr", rom_addr, 29);
            end
            if (r >= 31) chk("abort_outputs", {rom_en, dac_en, busy, done, rom_addr, period_cnt}, 0);
        end
        play(0, 1, 1, -1, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
